alif_neuron_core: RTL and testbench

- Parametrised adaptive leaky-integrate-and-fire neuron with N_SYN weighted synaptic inputs.
- Adds a programmable weight bank, saturating arithmetic, an absolute refractory period and a global timestep strobe.
- Drop-in replacement for the single-input neurons at the input layer of the SNN network. Several instances share one step strobe from the network sequencer.

---
 rtl/snn_pkg.sv | 20 ++
 rtl/syn_weight_bank.sv | 43 ++++
 rtl/alif_neuron_core.sv | 103 ++++++++++
 tb/tb_alif_neuron_core.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared arithmetic for the SNN neuron family: leak (exponential decay by shift)
// and saturating add, evaluated at a fixed wide width so callers never wrap.
package snn_pkg;

    localparam int CALC_W = 32;

    typedef logic [CALC_W-1:0] calc_t;

    // Decay by shift: x - x/2^shift. The result stays non-negative and never exceeds x.
    function automatic calc_t leak(input calc_t x, input int shift);
        return x - (x >> shift);
    endfunction

    function automatic calc_t sat_add(input calc_t a, input calc_t b, input calc_t max_val);
        calc_t s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/syn_weight_bank.sv
// Programmable synaptic weight register file with one write port and a
// combinational sum of the weights whose synapse line is active.
module syn_weight_bank #(
    parameter int DATA_W = 8,
    parameter int N_SYN  = 4,
    localparam int ADDR_W = (N_SYN > 1) ? $clog2(N_SYN) : 1,
    localparam int SUM_W  = DATA_W + $clog2(N_SYN) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SYN-1:0]  i_syn,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [SUM_W-1:0]  o_sum
);

    logic [DATA_W-1:0] r_weight [N_SYN];
    logic [SUM_W-1:0]  w_sum;

    // NOTE: the weights are plain flops rather than a RAM, so they take the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SYN; i++) r_weight[i] <= '0;
        end else begin
            // Address decode by equality, so an index >= N_SYN matches no entry.
            for (int i = 0; i < N_SYN; i++) begin
                if (i_wr_en && (i_wr_addr == ADDR_W'(i))) r_weight[i] <= i_wr_data;
            end
        end
    end

    // NOTE: the default assignment first guarantees no latch is inferred.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (i_syn[i]) w_sum = w_sum + SUM_W'(r_weight[i]);
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/alif_neuron_core.sv
// Adaptive leaky-integrate-and-fire neuron with N_SYN weighted inputs, an adaptive
// threshold and an absolute refractory period; state advances only on step strobes.
module alif_neuron_core
    import snn_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int N_SYN     = 4,
    parameter int ORI_THR   = 32,
    parameter int ADP_THR   = 2,
    parameter int SHIFT_CUR = 2,
    parameter int SHIFT_MEM = 2,
    parameter int SHIFT_THR = 2,
    parameter int REFRAC    = 2,
    localparam int ADDR_W   = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic [N_SYN-1:0]  syn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              spk,
    output logic [DATA_W-1:0] mem_out,
    output logic [DATA_W-1:0] thr_out,
    output logic              refrac
);

    localparam int    SUM_W   = DATA_W + $clog2(N_SYN) + 1;
    localparam int    RC_W    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam calc_t MAX_VAL = calc_t'((64'd1 << DATA_W) - 64'd1);
    localparam calc_t ORI_C   = calc_t'(ORI_THR);
    localparam calc_t ADP_C   = calc_t'(ADP_THR);

    if (ORI_THR > (2 ** DATA_W) - 1) begin : g_bad_ori_thr
        $error("ORI_THR does not fit in DATA_W bits");
    end
    if (N_SYN < 1) begin : g_bad_n_syn
        $error("N_SYN must be at least 1");
    end
    if (SUM_W + 2 > CALC_W) begin : g_bad_calc_w
        $error("snn_pkg::CALC_W too narrow for DATA_W/N_SYN");
    end

    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_mem;
    logic [DATA_W-1:0] r_thr;
    logic [RC_W-1:0]   r_rcnt;
    logic              r_spk;

    logic [SUM_W-1:0]  w_sum;
    logic              w_fire;
    calc_t             w_cur_next;
    calc_t             w_mem_next;
    calc_t             w_thr_next;

    syn_weight_bank #(
        .DATA_W (DATA_W),
        .N_SYN  (N_SYN)
    ) u_weight_bank (
        .clk       (clk),
        .reset     (reset),
        .i_syn     (syn),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .o_sum     (w_sum)
    );

    assign w_fire     = (r_mem >= r_thr) && (r_rcnt == '0);
    assign w_cur_next = sat_add(calc_t'(w_sum), leak(calc_t'(r_cur), SHIFT_CUR), MAX_VAL);
    assign w_mem_next = sat_add(calc_t'(r_cur), leak(calc_t'(r_mem), SHIFT_MEM), MAX_VAL);
    // thr >= ORI_THR always holds, so recovery decays only the excess above rest.
    assign w_thr_next = sat_add(ORI_C + leak(calc_t'(r_thr) - ORI_C, SHIFT_THR),
                                w_fire ? ADP_C : '0, MAX_VAL);

    // NOTE: non-blocking updates so every next-state term reads the pre-edge registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur  <= '0;
            r_mem  <= '0;
            r_thr  <= DATA_W'(ORI_THR);
            r_rcnt <= '0;
            r_spk  <= 1'b0;
        end else begin
            r_spk <= 1'b0;
            if (step) begin
                r_spk <= w_fire;
                r_cur <= DATA_W'(w_cur_next);
                r_thr <= DATA_W'(w_thr_next);
                r_mem <= (w_fire || (r_rcnt != '0)) ? '0 : DATA_W'(w_mem_next);
                if (w_fire)              r_rcnt <= RC_W'(REFRAC);
                else if (r_rcnt != '0)   r_rcnt <= r_rcnt - RC_W'(1);
            end
        end
    end

    assign spk     = r_spk;
    assign mem_out = r_mem;
    assign thr_out = r_thr;
    assign refrac  = (r_rcnt != '0);

endmodule

// File: tb/tb_alif_neuron_core.sv
// Scoreboard bench for alif_neuron_core: directed cycles push hand-computed
// expectations; a monitor pops one per clock edge and compares the outputs.
module tb_alif_neuron_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       step;
    logic [3:0] syn;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       spk;
    logic [7:0] mem_out;
    logic [7:0] thr_out;
    logic       refrac;

    typedef struct {
        string      nm;
        logic       spk;
        logic [7:0] mem;
        logic [7:0] thr;
        logic       refr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    alif_neuron_core dut (
        .clk     (clk),
        .reset   (reset),
        .step    (step),
        .syn     (syn),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .spk     (spk),
        .mem_out (mem_out),
        .thr_out (thr_out),
        .refrac  (refrac)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One clock of stimulus, driven after a falling edge; its expectation is
    // consumed by the monitor just after the following rising edge.
    task automatic cycle(input logic st, input logic [3:0] s, input logic we,
                         input logic [1:0] wa, input logic [7:0] wd, input string nm,
                         input logic e_spk, input logic [7:0] e_mem,
                         input logic [7:0] e_thr, input logic e_ref);
        exp_t e;
        @(negedge clk);
        step    = st;
        syn     = s;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        e.nm = nm; e.spk = e_spk; e.mem = e_mem; e.thr = e_thr; e.refr = e_ref;
        q.push_back(e);
    endtask

    task automatic check_idle_outputs(input string nm, input logic [7:0] e_thr);
        check({nm, "/spk"},    32'(spk),     32'd0);
        check({nm, "/mem"},    32'(mem_out), 32'd0);
        check({nm, "/thr"},    32'(thr_out), 32'(e_thr));
        check({nm, "/refrac"}, 32'(refrac),  32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        step  = 1'b0;
        wr_en = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.nm, "/spk"},    32'(spk),     32'(e.spk));
                check({e.nm, "/mem"},    32'(mem_out), 32'(e.mem));
                check({e.nm, "/thr"},    32'(thr_out), 32'(e.thr));
                check({e.nm, "/refrac"}, 32'(refrac),  32'(e.refr));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; step = 1'b0; syn = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        #3;
        check_idle_outputs("por", 8'd32);
        @(negedge clk);
        reset = 1'b0;

        // All weights zero after reset: cur and therefore mem stay 0.
        cycle(1, 4'hF, 0, 0, 0,   "zero_w_s1", 0, 0, 32, 0);
        cycle(1, 4'hF, 0, 0, 0,   "zero_w_s2", 0, 0, 32, 0);

        // Integrate, fire, refractory, re-integrate.
        cycle(0, 4'h0, 1, 0, 40,  "wr_w0",     0, 0,   32, 0);
        cycle(1, 4'h1, 0, 0, 0,   "int_s1",    0, 0,   32, 0);
        cycle(1, 4'h1, 0, 0, 0,   "int_s2",    0, 40,  32, 0);
        cycle(1, 4'h1, 0, 0, 0,   "fire_s3",   1, 0,   34, 1);
        cycle(1, 4'h1, 0, 0, 0,   "refr_s4",   0, 0,   34, 1);
        cycle(1, 4'h1, 0, 0, 0,   "refr_s5",   0, 0,   34, 0);
        cycle(1, 4'h1, 0, 0, 0,   "reint_s6",  0, 123, 34, 0);
        cycle(0, 4'h1, 0, 0, 0,   "idle_a",    0, 123, 34, 0);
        cycle(1, 4'h1, 0, 0, 0,   "fire_s7",   1, 0,   36, 1);

        // Async reset mid-clock while spiking and refractory (rcnt=2).
        @(posedge clk);
        #3;
        step  = 1'b0;
        syn   = '0;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_refr", 8'd32);
        #1;
        reset = 1'b0;

        // After release the weights are cleared again.
        cycle(1, 4'hF, 0, 0, 0,   "post_rst_s1", 0, 0, 32, 0);
        cycle(1, 4'h1, 0, 0, 0,   "post_rst_s2", 0, 0, 32, 0);

        // Saturation: four weights of 255 sum to 1020, cur clamps at 255.
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 1, 2'(i), 255, "wr_sat", 0, 0, 32, 0);
        cycle(1, 4'hF, 0, 0, 0,   "sat_s1", 0, 0,   32, 0);
        cycle(1, 4'hF, 0, 0, 0,   "sat_s2", 0, 255, 32, 0);
        cycle(1, 4'hF, 0, 0, 0,   "sat_s3", 1, 0,   34, 1);
        cycle(1, 4'hF, 0, 0, 0,   "sat_s4", 0, 0,   34, 1);
        cycle(1, 4'hF, 0, 0, 0,   "sat_s5", 0, 0,   34, 0);
        cycle(1, 4'hF, 0, 0, 0,   "sat_s6", 0, 255, 34, 0);

        // Write/step collision: old w1=5 used on the colliding step, 100 afterwards.
        pulse_reset();
        cycle(0, 4'h0, 1, 1, 5,   "wr_w1_old", 0, 0,   32, 0);
        cycle(1, 4'h2, 1, 1, 100, "coll_s1",   0, 0,   32, 0);
        cycle(1, 4'h2, 0, 0, 0,   "coll_s2",   0, 5,   32, 0);
        cycle(1, 4'h0, 0, 0, 0,   "coll_s3",   0, 108, 32, 0);
        for (int i = 0; i < 3; i++) cycle(0, 4'hF, 0, 0, 0, "gate_idle", 0, 108, 32, 0);
        cycle(1, 4'h0, 0, 0, 0,   "coll_fire", 1, 0,   34, 1);
        cycle(0, 4'h0, 0, 0, 0,   "spk_once",  0, 0,   34, 1);

        @(negedge clk);
        step  = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
